// File: rtl/if_fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signal bundle of the fetch stage.
// Latency: none, wires only.
// Backpressure: imem_gnt stalls fetch requests; if_ready stalls the decode-side slot.
// Optional IF_FETCH_ALIGN_CHECK_EN adds the fetch_misalign status signal.
interface if_fetch_unit_if;
  logic        pc_src;
  logic [31:0] target_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  // fetch-unit side
  modport master (
    input  pc_src, target_address, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
`ifdef IF_FETCH_ALIGN_CHECK_EN
    , output fetch_misalign
`endif
  );

  // memory / next-PC / decode side
  modport slave (
    output pc_src, target_address, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
`ifdef IF_FETCH_ALIGN_CHECK_EN
    , input fetch_misalign
`endif
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, one-entry decode slot.
// Latency: grant to if_valid = memory latency + 1 cycle; at most 1 instruction per 2 cycles.
// Backpressure: no request while the decode slot is held (if_valid && !if_ready) or imem_gnt=0.
// Optional IF_FETCH_ALIGN_CHECK_EN: misaligned redirect sets sticky fetch_misalign and stops fetch;
// without it the redirect target's low two bits are cleared.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus
);

  // IDLE: nothing outstanding; WAIT: response kept; SQUASH: response discarded
  typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, req_pc, redirect_pc;
  logic        slot_free, req, fire, load, consume, misalign;
  logic        valid_q;
  logic [31:0] instr_q, pc_q, pc4_q;

  assign slot_free        = !valid_q || bus.if_ready;
  assign consume          = valid_q && bus.if_ready;
  assign bus.imem_req     = req;
  assign bus.imem_addr    = pc;
  assign bus.if_valid     = valid_q;
  assign bus.if_instr     = instr_q;
  assign bus.if_pc        = pc_q;
  assign bus.if_pc_plus4  = pc4_q;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_pc        = bus.target_address;
  assign misalign           = misalign_q;
  assign bus.fetch_misalign = misalign_q;

  // Sticky flag: any misaligned redirect halts fetching until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (bus.pc_src && (bus.target_address[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
`else
  assign redirect_pc = bus.target_address & ~32'h3;
  assign misalign    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state, request and load decisions; a redirect never issues and never loads
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    fire      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        req  = slot_free && !bus.pc_src && !misalign;
        fire = req && bus.imem_gnt;
        if (fire)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          load      = !bus.pc_src;
          state_nxt = IDLE;
        end else if (bus.pc_src) begin
          state_nxt = SQUASH;
        end
      end
      SQUASH: begin
        if (bus.imem_rvalid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Architectural PC and the address of the outstanding request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= 32'h0;
    end else if (bus.pc_src) begin
      pc <= redirect_pc;
    end else if (fire) begin
      req_pc <= pc;
      pc     <= pc + 32'd4;
    end
  end

  // Decode-side slot: redirect flush beats load beats consume; payload holds when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
    end else if (bus.pc_src) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= bus.imem_rdata;
      pc_q    <= req_pc;
      pc4_q   <= req_pc + 32'd4;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed cycle table, reset/misalign sequences,
// and a randomized run against a queue-based transaction model.
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        src;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic src, input logic [31:0] tgt, input logic gnt,
                              input logic rv, input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.src = src; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic src, input logic [31:0] tgt, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    bus.pc_src         = src;
    bus.target_address = tgt;
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rd;
    bus.if_ready       = rdy;
  endtask

  // one cycle: drive after the rising edge, check combinational and registered outputs at the falling edge
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v.src, v.tgt, v.gnt, v.rv, v.rdata, v.rdy);
    @(negedge clk);
    check32($sformatf("%s.imem_req", tag), 32'(bus.imem_req), 32'(v.e_req));
    check32($sformatf("%s.imem_addr", tag), bus.imem_addr, v.e_addr);
    check32($sformatf("%s.if_valid", tag), 32'(bus.if_valid), 32'(v.e_v));
    check32($sformatf("%s.if_instr", tag), bus.if_instr, v.e_instr);
    check32($sformatf("%s.if_pc", tag), bus.if_pc, v.e_pc);
    check32($sformatf("%s.if_pc_plus4", tag), bus.if_pc_plus4, v.e_pc4);
  endtask

  // reference model state for the randomized run
  logic [31:0] exp_pc, pend_addr;
  int          ref_pend;
  logic        ref_mis;
  logic [31:0] out_instr[$];
  logic [31:0] out_pc[$];
  logic        m_busy;
  int          m_cnt;

  initial begin
    logic        src, gnt, rv, rdy, exp_req;
    logic [31:0] tgt, rd;

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    #2;
    check32("reset.if_valid", 32'(bus.if_valid), 32'd0);
    check32("reset.if_instr", bus.if_instr, 32'h0);
    check32("reset.if_pc", bus.if_pc, 32'h0);
    check32("reset.if_pc_plus4", bus.if_pc_plus4, 32'h0);
    check32("reset.imem_addr", bus.imem_addr, RST_PC);
`ifdef IF_FETCH_ALIGN_CHECK_EN
    check32("reset.fetch_misalign", 32'(bus.fetch_misalign), 32'd0);
`endif
    #10;
    reset = 1'b0;

    // src, tgt, gnt, rv, rdata, rdy | req, addr, valid, instr, pc, pc4
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400000, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 32'h11111111, 1,           0, 32'h00400004, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400004, 1, 32'h11111111, 32'h00400000, 32'h00400004));
    tab.push_back(mk(0, 0, 1, 1, 32'h22222222, 1,           0, 32'h00400008, 0, 32'h11111111, 32'h00400000, 32'h00400004));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400008, 1, 32'h22222222, 32'h00400004, 32'h00400008));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400008, 0, 32'h22222222, 32'h00400004, 32'h00400008));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400008, 0, 32'h22222222, 32'h00400004, 32'h00400008));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400008, 0, 32'h22222222, 32'h00400004, 32'h00400008));
    tab.push_back(mk(0, 0, 0, 0, 0, 0,                      0, 32'h0040000C, 0, 32'h22222222, 32'h00400004, 32'h00400008));
    tab.push_back(mk(0, 0, 0, 1, 32'h33333333, 0,           0, 32'h0040000C, 0, 32'h22222222, 32'h00400004, 32'h00400008));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0, 0, 1, 0, 0, 0,                    0, 32'h0040000C, 1, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h0040000C, 1, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(1, 32'h00400100, 0, 0, 0, 1,           0, 32'h00400010, 0, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 1,           0, 32'h00400100, 0, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400100, 0, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(0, 0, 1, 1, 32'h44444444, 1,           0, 32'h00400104, 0, 32'h33333333, 32'h00400008, 32'h0040000C));
    tab.push_back(mk(1, 32'h00400200, 0, 0, 0, 1,           0, 32'h00400104, 1, 32'h44444444, 32'h00400100, 32'h00400104));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400200, 0, 32'h44444444, 32'h00400100, 32'h00400104));
    tab.push_back(mk(0, 0, 1, 1, 32'h55555555, 0,           0, 32'h00400204, 0, 32'h44444444, 32'h00400100, 32'h00400104));
    tab.push_back(mk(0, 0, 1, 0, 0, 0,                      0, 32'h00400204, 1, 32'h55555555, 32'h00400200, 32'h00400204));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400204, 1, 32'h55555555, 32'h00400200, 32'h00400204));
    tab.push_back(mk(1, 32'h00400300, 1, 1, 32'h66666666, 0, 0, 32'h00400208, 0, 32'h55555555, 32'h00400200, 32'h00400204));
    tab.push_back(mk(0, 0, 1, 0, 0, 0,                      1, 32'h00400300, 0, 32'h55555555, 32'h00400200, 32'h00400204));
    tab.push_back(mk(0, 0, 1, 1, 32'h77777777, 0,           0, 32'h00400304, 0, 32'h55555555, 32'h00400200, 32'h00400204));
    tab.push_back(mk(0, 0, 1, 0, 0, 0,                      0, 32'h00400304, 1, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(1, 32'h00400400, 1, 0, 0, 1,           0, 32'h00400304, 1, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400400, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400400, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(1, 32'h00400500, 0, 0, 0, 1,           0, 32'h00400404, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(1, 32'h00400600, 0, 0, 0, 1,           0, 32'h00400500, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 0, 1, 32'hBAD0BAD0, 1,           0, 32'h00400600, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400600, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 0, 1, 32'hBADBAD00, 1,           1, 32'h00400600, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 0, 0, 0, 1,                      1, 32'h00400600, 0, 32'h77777777, 32'h00400300, 32'h00400304));
    tab.push_back(mk(0, 0, 1, 0, 0, 1,                      1, 32'h00400600, 0, 32'h77777777, 32'h00400300, 32'h00400304));

    for (int i = 0; i < tab.size(); i++)
      apply(tab[i], $sformatf("row%0d", i));

    // asynchronous reset while a request is outstanding, then a stale response
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check32("arst.if_valid", 32'(bus.if_valid), 32'd0);
    check32("arst.if_instr", bus.if_instr, 32'h0);
    check32("arst.if_pc", bus.if_pc, 32'h0);
    check32("arst.if_pc_plus4", bus.if_pc_plus4, 32'h0);
    check32("arst.imem_addr", bus.imem_addr, RST_PC);
    #1 reset = 1'b0;
    apply(mk(0, 0, 0, 1, 32'hCAFEF00D, 1, 1, RST_PC, 0, 0, 0, 0), "stale0");
    apply(mk(0, 0, 0, 0, 0, 1,            1, RST_PC, 0, 0, 0, 0), "stale1");
    apply(mk(0, 0, 1, 0, 0, 1,            1, RST_PC, 0, 0, 0, 0), "refetch0");
    apply(mk(0, 0, 0, 1, 32'h12345678, 0, 0, 32'h00400004, 0, 0, 0, 0), "refetch1");
    apply(mk(0, 0, 0, 0, 0, 0,            0, 32'h00400004, 1, 32'h12345678, RST_PC, 32'h00400004), "refetch2");

    // randomized run against the transaction model
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    #2 reset = 1'b0;
    exp_pc = RST_PC; ref_pend = 0; ref_mis = 1'b0; m_busy = 1'b0; m_cnt = 0;
    out_instr.delete(); out_pc.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      src = ($urandom_range(0, 19) == 0);
      tgt = 32'h0040_0000 | (32'($urandom_range(0, 1023)) << 2);
`ifndef IF_FETCH_ALIGN_CHECK_EN
      tgt = tgt | 32'($urandom_range(0, 3));
`endif
      gnt = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = 1'b0;
      rd  = 32'h0;
      if (m_busy && m_cnt == 0) begin
        rv = 1'b1;
        rd = $urandom;
      end else if (m_busy) begin
        m_cnt--;
      end
      drive(src, tgt, gnt, rv, rd, rdy);
      @(negedge clk);

      exp_req = (ref_pend == 0) && (out_instr.size() == 0 || rdy) && !src && !ref_mis;
      check32("rnd.imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req)
        check32("rnd.imem_addr", bus.imem_addr, exp_pc);
      check32("rnd.if_valid", 32'(bus.if_valid), 32'(out_instr.size() != 0));
      if (out_instr.size() != 0) begin
        check32("rnd.if_instr", bus.if_instr, out_instr[0]);
        check32("rnd.if_pc", bus.if_pc, out_pc[0]);
        check32("rnd.if_pc_plus4", bus.if_pc_plus4, out_pc[0] + 32'd4);
      end

      // memory responds only to grants it actually saw
      if (rv) m_busy = 1'b0;
      if (bus.imem_req && gnt) begin
        m_busy = 1'b1;
        m_cnt  = $urandom_range(0, 2);
      end

      if (src) begin
        out_instr.delete();
        out_pc.delete();
        if (ref_pend != 0) ref_pend = rv ? 0 : 2;
`ifdef IF_FETCH_ALIGN_CHECK_EN
        exp_pc = tgt;
        if (tgt[1:0] != 2'b00) ref_mis = 1'b1;
`else
        exp_pc = {tgt[31:2], 2'b00};
`endif
      end else begin
        if (out_instr.size() != 0 && rdy) begin
          void'(out_instr.pop_front());
          void'(out_pc.pop_front());
        end
        if (rv && ref_pend != 0) begin
          if (ref_pend == 1) begin
            out_instr.push_back(rd);
            out_pc.push_back(pend_addr);
          end
          ref_pend = 0;
        end
        if (exp_req && gnt) begin
          ref_pend  = 1;
          pend_addr = exp_pc;
          exp_pc    = exp_pc + 32'd4;
        end
      end
    end

    // misaligned redirect
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    #2 reset = 1'b0;
    apply(mk(1, 32'h00400102, 1, 0, 0, 1, 0, RST_PC, 0, 0, 0, 0), "misalign0");
`ifdef IF_FETCH_ALIGN_CHECK_EN
    apply(mk(0, 0, 1, 0, 0, 1, 0, 32'h00400102, 0, 0, 0, 0), "misalign1");
    check32("misalign.flag", 32'(bus.fetch_misalign), 32'd1);
    apply(mk(0, 0, 1, 0, 0, 1, 0, 32'h00400102, 0, 0, 0, 0), "misalign2");
`else
    apply(mk(0, 0, 1, 0, 0, 1, 1, 32'h00400100, 0, 0, 0, 0), "misalign1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
